// File: rtl/dmem_window_ctrl.sv
// Windowed data store behind a valid/ready port with a 1- or 2-stage read pipeline and a clear sweep after reset.
// Define DMEM_PARITY_EN to add a stored even-parity bit per word (parity_inj / parity_err ports).
module dmem_window_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int BASE     = 64,
    parameter int DEPTH    = 64,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
`ifdef DMEM_PARITY_EN
    ,
    input  logic              parity_inj,
    output logic              parity_err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so BASE+DEPTH == 2^ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(BASE + DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              hit;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] rd_word;

    assign accept  = req_valid & req_ready;
    assign hit     = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
    assign index   = IDX_W'(req_addr - ADDR_W'(BASE));
    assign rd_word = hit ? mem[index] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            idx       <= '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (idx == IDX_W'(DEPTH - 1)) begin
                        state     <= READY;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the post-reset sweep clears it, keeping it RAM-mappable.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[idx] <= '0;
        end else if (accept && req_we && hit) begin
            mem[index] <= req_wdata;
        end
    end

`ifdef DMEM_PARITY_EN
    logic par_store [DEPTH];
    logic rd_perr;

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            par_store[idx] <= 1'b0;
        end else if (accept && req_we && hit) begin
            par_store[index] <= (^req_wdata) ^ parity_inj;
        end
    end

    assign rd_perr = hit && !req_we && ((^mem[index]) != par_store[index]);
`endif

    // Head of the response pipeline: the request itself (READ_LAT=1) or one registered stage (READ_LAT=2).
    logic              head_valid;
    logic              head_err;
    logic              head_load;
    logic [DATA_W-1:0] head_data;
`ifdef DMEM_PARITY_EN
    logic              head_perr;
`endif

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              s_valid;
            logic              s_err;
            logic              s_load;
            logic [DATA_W-1:0] s_data;
`ifdef DMEM_PARITY_EN
            logic              s_perr;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_valid <= 1'b0;
                    s_err   <= 1'b0;
                    s_load  <= 1'b0;
                    s_data  <= '0;
`ifdef DMEM_PARITY_EN
                    s_perr  <= 1'b0;
`endif
                end else begin
                    s_valid <= accept;
                    s_err   <= !hit;
                    s_load  <= !req_we;
                    s_data  <= rd_word;
`ifdef DMEM_PARITY_EN
                    s_perr  <= rd_perr;
`endif
                end
            end

            assign head_valid = s_valid;
            assign head_err   = s_err;
            assign head_load  = s_load;
            assign head_data  = s_data;
`ifdef DMEM_PARITY_EN
            assign head_perr  = s_perr;
`endif
        end else begin : g_lat1
            assign head_valid = accept;
            assign head_err   = !hit;
            assign head_load  = !req_we;
            assign head_data  = rd_word;
`ifdef DMEM_PARITY_EN
            assign head_perr  = rd_perr;
`endif
        end
    endgenerate

    // rsp_rdata only moves on read responses so it holds between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
`ifdef DMEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rsp_valid  <= head_valid;
            rsp_err    <= head_valid & head_err;
`ifdef DMEM_PARITY_EN
            parity_err <= head_valid & head_perr;
`endif
            if (head_valid && head_load) begin
                rsp_rdata <= head_data;
            end
        end
    end

endmodule
